// File: rtl/nes_poll_scheduler.sv
// Polls NES controllers periodically or on demand, captures button bytes, derives press/release edges.
// Latency: poll_now_i -> start_fetch_o 1 cycle; fetch completion -> frame_valid_o 2 cycles; frames held until accepted.
module nes_poll_scheduler #(
    parameter int NUM_CONTROLLERS = 4,
    parameter int POLL_PERIOD     = 8333,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable_i,
    input  logic                         poll_now_i,
    output logic                         start_fetch_o,
    input  logic                         fetch_valid_i,
    input  logic [8*NUM_CONTROLLERS-1:0] fetch_data_i,
    output logic [8*NUM_CONTROLLERS-1:0] buttons_o,
    output logic [8*NUM_CONTROLLERS-1:0] pressed_o,
    output logic [8*NUM_CONTROLLERS-1:0] released_o,
    output logic                         overrun_o,
    output logic                         frame_valid_o,
    input  logic                         frame_ready_i,
    output logic                         timeout_o
);

    localparam int W  = 8*NUM_CONTROLLERS;
    localparam int PW = $clog2(POLL_PERIOD);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] PERIOD_RELOAD  = PW'(POLL_PERIOD-1);
    localparam logic [TW-1:0] TIMEOUT_RELOAD = TW'(TIMEOUT_CYCLES-1);

    typedef enum logic [1:0] {IDLE, ARMED, BUSY, CAPTURE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   pcnt;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic            pending, pending_nxt;
    logic [W-1:0]    cap, cap_nxt;
    logic [W-1:0]    buttons_nxt, pressed_nxt, released_nxt;
    logic [W-1:0]    new_p, new_r;
    logic            overrun_nxt, frame_valid_nxt, start_nxt, timeout_nxt;
    logic            tick, trigger, launch, accept, expire;

    assign tick    = enable_i && (pcnt == '0);
    assign trigger = tick || poll_now_i;
    assign launch  = (state == IDLE) && (trigger || pending) && fetch_valid_i;
    assign accept  = frame_valid_o && frame_ready_i;
    // Expiry loses to a completing fetch in BUSY; in ARMED it always wins.
    assign expire  = (tcnt == '0) &&
                     ((state == ARMED) || ((state == BUSY) && !fetch_valid_i));
    assign new_p   = cap & ~buttons_o;
    assign new_r   = ~cap & buttons_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= PERIOD_RELOAD;
        end else if (!enable_i || pcnt == '0) begin
            pcnt <= PERIOD_RELOAD;
        end else begin
            pcnt <= pcnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = ARMED;
            ARMED:   if (expire) state_nxt = IDLE;
                     else if (!fetch_valid_i) state_nxt = BUSY;
            BUSY:    if (fetch_valid_i) state_nxt = CAPTURE;
                     else if (expire) state_nxt = IDLE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pending_nxt     = pending;
        tcnt_nxt        = tcnt;
        cap_nxt         = cap;
        buttons_nxt     = buttons_o;
        pressed_nxt     = pressed_o;
        released_nxt    = released_o;
        overrun_nxt     = overrun_o;
        frame_valid_nxt = frame_valid_o;
        start_nxt       = 1'b0;
        timeout_nxt     = expire;

        if (launch)       pending_nxt = 1'b0;
        else if (trigger) pending_nxt = 1'b1;

        if (launch) begin
            start_nxt = 1'b1;
            tcnt_nxt  = TIMEOUT_RELOAD;
        end else if ((state == ARMED || state == BUSY) && tcnt != '0) begin
            tcnt_nxt = tcnt - 1'b1;
        end

        if (state == BUSY && fetch_valid_i) cap_nxt = fetch_data_i;

        if (accept) frame_valid_nxt = 1'b0;

        if (state == CAPTURE) begin
            buttons_nxt     = cap;
            frame_valid_nxt = 1'b1;
            if (!frame_valid_o || accept) begin
                pressed_nxt  = new_p;
                released_nxt = new_r;
                overrun_nxt  = 1'b0;
            end else begin
                // Consumer missed a frame: accumulate edges so none are lost.
                pressed_nxt  = pressed_o | new_p;
                released_nxt = released_o | new_r;
                overrun_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending       <= 1'b0;
            tcnt          <= '0;
            cap           <= '0;
            buttons_o     <= '0;
            pressed_o     <= '0;
            released_o    <= '0;
            overrun_o     <= 1'b0;
            frame_valid_o <= 1'b0;
            start_fetch_o <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            pending       <= pending_nxt;
            tcnt          <= tcnt_nxt;
            cap           <= cap_nxt;
            buttons_o     <= buttons_nxt;
            pressed_o     <= pressed_nxt;
            released_o    <= released_nxt;
            overrun_o     <= overrun_nxt;
            frame_valid_o <= frame_valid_nxt;
            start_fetch_o <= start_nxt;
            timeout_o     <= timeout_nxt;
        end
    end

endmodule
